// File: rtl/fifo_push_arbiter_pkg.sv
// Shared constants, state encoding and CPU address map for the FIFO push arbiter.
package fifo_push_arbiter_pkg;

    localparam int unsigned NUM_PORTS   = 4;
    localparam int unsigned DATA_WIDTH  = 256;
    localparam int unsigned CNT_WIDTH   = 32;
    localparam int unsigned OWNER_WIDTH = 2;

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } state_e;

    // Addresses 0-3 select beat counters, 4-7 packet counters; bit 2 picks the bank.
    localparam logic [2:0]  CPU_ADDR_BEAT_BASE = 3'd0;
    localparam logic [2:0]  CPU_ADDR_PKT_BASE  = 3'd4;
    localparam int unsigned CPU_ADDR_SEL_BIT   = 2;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick4.sv
// Round-robin first-set search over four requests, starting at pointer and wrapping upward.
module fifo_push_arbiter_rr_pick4
    import fifo_push_arbiter_pkg::*;
(
    input  logic [3:0]             request,
    input  logic [OWNER_WIDTH-1:0] pointer,
    output logic [OWNER_WIDTH-1:0] index,
    output logic                   any
);

    logic [OWNER_WIDTH-1:0] cand;

    // Scan farthest candidate first so the one nearest the pointer wins.
    always_comb begin
        index = pointer;
        any   = 1'b0;
        cand  = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = pointer + OWNER_WIDTH'(i);
            if (request[cand]) begin
                index = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Packet-locked round-robin arbiter feeding a shared FIFO, with per-port beat/packet
// counters readable over a simple one-cycle CPU read port.
module fifo_push_arbiter #(
    parameter int unsigned NUM_PORTS  = fifo_push_arbiter_pkg::NUM_PORTS,
    parameter int unsigned DATA_WIDTH = fifo_push_arbiter_pkg::DATA_WIDTH
) (
    input  logic                            clockCore,
    input  logic                            resetCore,
    input  logic [NUM_PORTS-1:0]            reqValid,
    input  logic [NUM_PORTS-1:0]            reqLast,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] reqData,
    output logic [NUM_PORTS-1:0]            reqReady,
    input  logic [NUM_PORTS-1:0]            portEnable,
    input  logic                            fifoFull,
    output logic                            fifoPush,
    output logic [DATA_WIDTH-1:0]           fifoDataIn,
    output logic                            grantActive,
    output logic [1:0]                      grantOwner,
    input  logic                            cpuReadValid,
    input  logic [2:0]                      cpuReadAddress,
    output logic                            cpuReadAck,
    output logic [31:0]                     cpuReadData
);

    import fifo_push_arbiter_pkg::*;

    state_e                 state_q, state_d;
    logic [OWNER_WIDTH-1:0] owner_q, owner_d;
    logic [OWNER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   beat_cnt_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   pkt_cnt_q  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   pkt_cnt_d  [NUM_PORTS];
    logic                   ack_q, ack_d;
    logic [CNT_WIDTH-1:0]   rdata_q, rdata_d;

    logic [OWNER_WIDTH-1:0] pick_idx;
    logic                   pick_any;
    logic                   locked;
    logic                   transfer;
    logic                   last_xfer;

    fifo_push_arbiter_rr_pick4 u_pick (
        .request (reqValid & portEnable),
        .pointer (rr_ptr_q),
        .index   (pick_idx),
        .any     (pick_any)
    );

    // Reset gating keeps push/ready low in the reset cycle itself.
    always_comb begin
        locked    = (state_q == StLocked);
        transfer  = locked && reqValid[owner_q] && !fifoFull && !resetCore;
        last_xfer = transfer && reqLast[owner_q];

        reqReady = '0;
        if (locked && !fifoFull && !resetCore) begin
            reqReady[owner_q] = 1'b1;
        end
        fifoPush    = transfer;
        fifoDataIn  = reqData[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
        grantActive = locked;
        grantOwner  = owner_q;
        cpuReadAck  = ack_q;
        cpuReadData = rdata_q;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StLocked;
                    owner_d = pick_idx;
                end
            end
            StLocked: begin
                if (last_xfer) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            beat_cnt_d[i] = beat_cnt_q[i];
            pkt_cnt_d[i]  = pkt_cnt_q[i];
            if (transfer && owner_q == OWNER_WIDTH'(i)) begin
                beat_cnt_d[i] = beat_cnt_q[i] + 32'd1;
            end
            if (last_xfer && owner_q == OWNER_WIDTH'(i)) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
            end
        end

        // Read samples the current (pre-increment) counter value.
        ack_d   = cpuReadValid;
        rdata_d = rdata_q;
        if (cpuReadValid) begin
            if (cpuReadAddress[CPU_ADDR_SEL_BIT]) begin
                rdata_d = pkt_cnt_q[cpuReadAddress[1:0]];
            end else begin
                rdata_d = beat_cnt_q[cpuReadAddress[1:0]];
            end
        end
    end

    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                beat_cnt_q[i] <= '0;
                pkt_cnt_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                beat_cnt_q[i] <= beat_cnt_d[i];
                pkt_cnt_q[i]  <= pkt_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed self-checking bench for fifo_push_arbiter; ports are driven by a simple
// per-port beat source that advances only when the DUT accepts a beat.
module tb_fifo_push_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_last;
    logic [1023:0] req_data;
    logic [3:0]    req_ready;
    logic [3:0]    port_enable;
    logic          fifo_full;
    logic          fifo_push;
    logic [255:0]  fifo_data_in;
    logic          grant_active;
    logic [1:0]    grant_owner;
    logic          cpu_rd_valid;
    logic [2:0]    cpu_rd_addr;
    logic          cpu_rd_ack;
    logic [31:0]   cpu_rd_data;

    int errors = 0;
    int checks = 0;
    int rem[4];
    int sent[4];
    logic [3:0] stall;
    int push_cnt;
    int sz[5];

    fifo_push_arbiter dut (
        .clockCore      (clk),
        .resetCore      (rst),
        .reqValid       (req_valid),
        .reqLast        (req_last),
        .reqData        (req_data),
        .reqReady       (req_ready),
        .portEnable     (port_enable),
        .fifoFull       (fifo_full),
        .fifoPush       (fifo_push),
        .fifoDataIn     (fifo_data_in),
        .grantActive    (grant_active),
        .grantOwner     (grant_owner),
        .cpuReadValid   (cpu_rd_valid),
        .cpuReadAddress (cpu_rd_addr),
        .cpuReadAck     (cpu_rd_ack),
        .cpuReadData    (cpu_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] exp_data(input int p, input int b);
        return 256'({8'(p), 8'(b)});
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply source state to the request inputs and let combinational outputs settle.
    task automatic drive_settle();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (rem[i] > 0) && !stall[i];
            req_last[i]  = (rem[i] == 1);
            req_data[i*256 +: 256] = exp_data(i, sent[i]);
        end
        #1;
    endtask

    task automatic adv();
        logic [3:0] rdy;
        rdy = req_ready & req_valid;
        if (fifo_push) push_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                rem[i]--;
                sent[i]++;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
        end
        stall        = '0;
        fifo_full    = 1'b0;
        port_enable  = 4'hF;
        cpu_rd_valid = 1'b0;
        cpu_rd_addr  = '0;
        rst          = 1'b1;
        drive_settle();
        adv();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        port_enable = 4'hF;
        fifo_full = 1'b0;
        cpu_rd_valid = 1'b0;
        cpu_rd_addr = '0;
        stall = '0;
        push_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
        end

        // Reset state
        drive_settle();
        chk("rst_push", 256'(fifo_push), 0);
        chk("rst_ready", 256'(req_ready), 0);
        adv();
        rst = 1'b0;
        drive_settle();
        chk("rst_active", 256'(grant_active), 0);
        chk("rst_owner", 256'(grant_owner), 0);
        chk("rst_ack", 256'(cpu_rd_ack), 0);
        chk("rst_rdata", 256'(cpu_rd_data), 0);

        // All four ports send a 2-beat packet at once: idle, beat, beat per port
        for (int i = 0; i < 4; i++) rem[i] = 2;
        push_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            drive_settle();
            chk("rr_active", 256'(grant_active), 256'((k % 3) != 0));
            chk("rr_push", 256'(fifo_push), 256'((k % 3) != 0));
            if ((k % 3) != 0) begin
                chk("rr_owner", 256'(grant_owner), 256'(k / 3));
                chk("rr_data", fifo_data_in, exp_data(k / 3, (k % 3) - 1));
            end
            adv();
        end
        drive_settle();
        chk("rr_end_idle", 256'(grant_active), 0);
        chk("rr_push_count", 256'(push_cnt), 8);
        adv();
        // Pointer wrapped to 0: port 0 beats port 3
        rem[0] = 1;
        rem[3] = 1;
        drive_settle();
        adv();
        drive_settle();
        chk("rr_wrap_owner", 256'(grant_owner), 0);
        chk("rr_wrap_push", 256'(fifo_push), 1);
        adv();
        drive_settle();
        adv();
        drive_settle();
        chk("rr_wrap_owner3", 256'(grant_owner), 3);
        adv();

        // Port 2 stalled by fifoFull for 3 cycles mid-packet
        do_reset();
        rem[2] = 4;
        drive_settle();
        chk("full_idle_push", 256'(fifo_push), 0);
        adv();
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 3'd2;
        drive_settle();
        chk("full_b0_push", 256'(fifo_push), 1);
        chk("full_b0_ready", 256'(req_ready), 256'(4'b0100));
        chk("full_b0_data", fifo_data_in, exp_data(2, 0));
        adv();
        cpu_rd_valid = 1'b0;
        drive_settle();
        chk("rd_pre_inc_ack", 256'(cpu_rd_ack), 1);
        chk("rd_pre_inc_data", 256'(cpu_rd_data), 0);
        chk("full_b1_data", fifo_data_in, exp_data(2, 1));
        adv();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_settle();
            chk("full_push", 256'(fifo_push), 0);
            chk("full_ready", 256'(req_ready), 0);
            chk("full_active", 256'(grant_active), 1);
            adv();
        end
        fifo_full = 1'b0;
        drive_settle();
        chk("full_b2_push", 256'(fifo_push), 1);
        chk("full_b2_data", fifo_data_in, exp_data(2, 2));
        adv();
        drive_settle();
        chk("full_b3_data", fifo_data_in, exp_data(2, 3));
        adv();
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 3'd2;
        drive_settle();
        chk("full_end_idle", 256'(grant_active), 0);
        adv();
        cpu_rd_addr = 3'd6;
        drive_settle();
        chk("full_beats", 256'(cpu_rd_data), 4);
        adv();
        cpu_rd_valid = 1'b0;
        drive_settle();
        chk("full_pkts", 256'(cpu_rd_data), 1);
        adv();
        drive_settle();
        chk("rd_ack_drop", 256'(cpu_rd_ack), 0);

        // Port 1 loses enable and drops valid mid-packet; lock holds, then port 3
        do_reset();
        rem[1] = 4;
        rem[3] = 1;
        drive_settle();
        adv();
        drive_settle();
        chk("en_owner", 256'(grant_owner), 1);
        chk("en_ready", 256'(req_ready), 256'(4'b0010));
        chk("en_b0_data", fifo_data_in, exp_data(1, 0));
        adv();
        port_enable[1] = 1'b0;
        drive_settle();
        chk("en_b1_data", fifo_data_in, exp_data(1, 1));
        chk("en_b1_push", 256'(fifo_push), 1);
        adv();
        stall[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_settle();
            chk("stall_active", 256'(grant_active), 1);
            chk("stall_owner", 256'(grant_owner), 1);
            chk("stall_push", 256'(fifo_push), 0);
            adv();
        end
        stall[1] = 1'b0;
        drive_settle();
        chk("en_b2_data", fifo_data_in, exp_data(1, 2));
        adv();
        drive_settle();
        chk("en_b3_data", fifo_data_in, exp_data(1, 3));
        chk("en_b3_push", 256'(fifo_push), 1);
        adv();
        drive_settle();
        chk("en_gap_idle", 256'(grant_active), 0);
        adv();
        drive_settle();
        chk("en_next_owner", 256'(grant_owner), 3);
        chk("en_next_data", fifo_data_in, exp_data(3, 0));
        adv();

        // Port 0: 5 packets, 17 beats, then read both counters back to back
        do_reset();
        sz[0] = 4; sz[1] = 4; sz[2] = 3; sz[3] = 3; sz[4] = 3;
        push_cnt = 0;
        for (int p = 0; p < 5; p++) begin
            rem[0] = sz[p];
            for (int c = 0; c < 20 && rem[0] > 0; c++) begin
                drive_settle();
                adv();
            end
            chk("pkt_timeout", 256'(rem[0]), 0);
        end
        chk("cnt_pushes", 256'(push_cnt), 17);
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 3'd0;
        drive_settle();
        chk("cnt_req_ack", 256'(cpu_rd_ack), 0);
        adv();
        cpu_rd_addr = 3'd4;
        drive_settle();
        chk("cnt_beat_ack", 256'(cpu_rd_ack), 1);
        chk("cnt_beats", 256'(cpu_rd_data), 17);
        adv();
        cpu_rd_valid = 1'b0;
        drive_settle();
        chk("cnt_pkt_ack", 256'(cpu_rd_ack), 1);
        chk("cnt_pkts", 256'(cpu_rd_data), 5);
        adv();
        drive_settle();
        chk("cnt_ack_drop", 256'(cpu_rd_ack), 0);

        // Reset during beat 2 of a 4-beat packet on port 3
        do_reset();
        rem[3] = 4;
        drive_settle();
        adv();
        drive_settle();
        chk("mr_b0_data", fifo_data_in, exp_data(3, 0));
        adv();
        rst = 1'b1;
        drive_settle();
        chk("mr_push", 256'(fifo_push), 0);
        chk("mr_ready", 256'(req_ready), 0);
        adv();
        rst = 1'b0;
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 3'd3;
        drive_settle();
        chk("mr_idle", 256'(grant_active), 0);
        chk("mr_idle_push", 256'(fifo_push), 0);
        adv();
        cpu_rd_addr = 3'd7;
        drive_settle();
        chk("mr_beats_zero", 256'(cpu_rd_data), 0);
        chk("mr_regrant", 256'(grant_owner), 3);
        chk("mr_b1_data", fifo_data_in, exp_data(3, 1));
        chk("mr_b1_push", 256'(fifo_push), 1);
        adv();
        cpu_rd_valid = 1'b0;
        drive_settle();
        chk("mr_pkts_zero", 256'(cpu_rd_data), 0);
        chk("mr_b2_data", fifo_data_in, exp_data(3, 2));
        adv();
        drive_settle();
        chk("mr_b3_data", fifo_data_in, exp_data(3, 3));
        adv();
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 3'd3;
        drive_settle();
        chk("mr_end_idle", 256'(grant_active), 0);
        adv();
        cpu_rd_addr = 3'd7;
        drive_settle();
        chk("mr_beats", 256'(cpu_rd_data), 3);
        adv();
        cpu_rd_valid = 1'b0;
        drive_settle();
        chk("mr_pkts", 256'(cpu_rd_data), 1);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
